nfc_rx_capture_ctrl: RTL and testbench
======================================

Name: nfc_rx_capture_ctrl

Overview:
Sequences the ADC serial-read front end for one NFC receive window. A reader-side tx_done starts the window; the block waits a guard time, enables the ADC frame generator, discards warm-up conversions, and captures a programmed number of 12-bit samples into a small FIFO. The FIFO feeds the DSP chain over a valid/ready stream. The block sits between the ADC read block (adc_data_en/adc_data, frame enable) and the subcarrier demodulator.

Parameters:
DATA_W, 12, ADC sample width
GUARD_W, 16, width of guard-time counter (clk cycles)
LEN_W, 16, width of sample-count counter
DISCARD, 2, number of ADC conversions dropped after adc_run rises (valid range 0..3)
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  system clock (81.36 MHz)
rstn  in  1  synchronous active-low reset
tx_done  in  1  single-cycle pulse: reader transmission finished, start window
abort  in  1  single-cycle pulse: cancel window, flush
cfg_guard  in  GUARD_W  guard cycles between tx_done and adc_run
cfg_len  in  LEN_W  samples to capture (0 = empty window)
adc_run  out  1  enable to ADC read block; 1 = generate conversion frames
adc_data_en  in  1  one-cycle strobe: new ADC sample valid
adc_data  in  DATA_W  ADC sample
smp_valid  out  1  stream valid
smp_ready  in  1  stream ready
smp_data  out  DATA_W  stream sample
smp_last  out  1  marks final sample of window
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: window complete and FIFO drained
ovf  out  1  sticky: at least one sample dropped in current/last window

Behaviour:
- Decided: one clock, clk. Reset rstn is synchronous, active-low. All state updates on posedge clk.
- Reset values: adc_run=0, smp_valid=0, smp_data=0, smp_last=0, busy=0, done=0, ovf=0. FIFO is empty and state is IDLE.
- States: IDLE, GUARD, WARM, CAPTURE, DRAIN.
- IDLE, on tx_done:
  - Latch cfg_guard and cfg_len; clear ovf.
  - If cfg_len==0: pulse done at t+1 and stay in IDLE; adc_run is never asserted.
  - Otherwise go to GUARD.
- GUARD: the counter loads the latched guard value and decrements each cycle. adc_run rises exactly at cycle t+1+G, where t is the tx_done cycle and G the latched guard. The state moves to WARM at the same edge; G=0 gives adc_run at t+1.
- WARM: adc_run=1. Count adc_data_en strobes; the first DISCARD are dropped. After the last discard, go to CAPTURE. With DISCARD=0, go to CAPTURE directly from GUARD instead of WARM.
- CAPTURE: each adc_data_en pushes {last, adc_data} and increments the sample count.
  - last=1 when count reaches latched len.
  - On that push, adc_run drops at the next edge and the state moves to DRAIN.
- DRAIN: wait until the FIFO is empty. done then pulses for 1 cycle and the state returns to IDLE.
- adc_data_en is ignored in IDLE, GUARD and DRAIN.
- tx_done is ignored when not in IDLE.
- FIFO and stream:
  - A pushed sample is visible on smp_valid/smp_data at the next cycle (1-cycle latency).
  - smp_data and smp_last hold stable while smp_valid && !smp_ready.
  - Pop occurs when smp_valid && smp_ready.
- FIFO full:
  - A push while full with no same-cycle pop is dropped and ovf is set.
  - The sample count still increments, so window duration is preserved.
  - If the dropped sample was the last one, no smp_last is emitted; DRAIN/done still complete.
  - Full with a same-cycle pop: the push is accepted.
- abort in any non-IDLE state: the next cycle gives adc_run=0, FIFO flushed, smp_valid=0, state IDLE, no done. ovf keeps its value.
- Priority: abort has priority over same-cycle tx_done, adc_data_en and pop. abort in IDLE has no effect.
- Counters never wrap. The sample counter stops at len.
- Reset asserted mid-window returns all outputs to reset values at that edge, regardless of other inputs.

Test Plan:
1. Basic window: cfg_guard=5, cfg_len=4, DISCARD=2, tx_done at t. Drive strobes 0x100..0x105 with smp_ready=1.
   - adc_run rises at t+6.
   - Stream carries 0x102,0x103,0x104,0x105 with smp_last only on 0x105.
   - adc_run falls the cycle after the 0x105 strobe; done pulses once when the FIFO is empty; ovf=0.
2. Backpressure/overflow: cfg_len=8, FIFO_AW=2, smp_ready=0 throughout capture, then 1.
   - First 4 samples are delivered; ovf=1; no smp_last; done still pulses.
   - Next tx_done clears ovf.
3. Full with simultaneous pop: FIFO holds 4 entries; strobe and pop occur in the same cycle → new sample accepted, ovf stays 0.
4. Abort mid-capture, same cycle as a strobe: sample not stored; next cycle adc_run=0, smp_valid=0, busy=0; no done.
5. Edge configs: cfg_len=0 → done at t+1 and adc_run never high. cfg_guard=0 → adc_run at t+1. tx_done during CAPTURE is ignored.
6. Reset: rstn=0 during DRAIN with smp_valid=1 → at that edge all outputs reach reset values; a following tx_done starts a clean window.

Source files
------------

// File: rtl/nfc_rx_capture_ctrl.sv
// NFC receive-window capture controller.
// Waits a guard time after the reader finishes transmitting, runs the ADC,
// throws away warm-up conversions, then buffers a programmed number of
// samples in a small FIFO that feeds the demodulator over valid/ready.
module nfc_rx_capture_ctrl #(
    parameter int DATA_W  = 12,
    parameter int GUARD_W = 16,
    parameter int LEN_W   = 16,
    parameter int DISCARD = 2,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tx_done,
    input  logic               abort,
    input  logic [GUARD_W-1:0] cfg_guard,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic               adc_run,
    input  logic               adc_data_en,
    input  logic [DATA_W-1:0]  adc_data,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [DATA_W-1:0]  smp_data,
    output logic               smp_last,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        WARM,
        CAPTURE,
        DRAIN
    } state_t;

    // With no warm-up conversions to drop, the guard time leads straight to capture.
    localparam state_t     AFTER_GUARD = (DISCARD == 0) ? CAPTURE : WARM;
    localparam logic [1:0] DISC_LAST   = 2'((DISCARD == 0) ? 0 : DISCARD - 1);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    state_t state;
    state_t state_nxt;

    logic [GUARD_W-1:0] guard_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   smp_cnt;
    logic [LEN_W-1:0]   smp_cnt_inc;
    logic [1:0]         disc_cnt;

    logic [DATA_W:0]    mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;

    logic               abort_act;
    logic               start;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;
    logic               last_smp;
    logic               done_q;
    logic               ovf_q;

    assign abort_act   = abort && (state != IDLE);
    assign start       = tx_done && (state == IDLE);
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                         (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop         = !fifo_empty && smp_ready && !abort_act;
    assign push_req    = (state == CAPTURE) && adc_data_en && !abort_act;
    // A full FIFO can still take a sample when the head leaves in the same cycle.
    assign push        = push_req && (!fifo_full || pop);
    assign drop        = push_req && fifo_full && !pop;
    assign smp_cnt_inc = smp_cnt + LEN_W'(1);
    // Dropped samples still count, so the window length stays fixed.
    assign last_smp    = push_req && (smp_cnt_inc == len_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_done && (cfg_len != '0)) begin
                        state_nxt = (cfg_guard == '0) ? AFTER_GUARD : GUARD;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_W'(1)) begin
                        state_nxt = AFTER_GUARD;
                    end
                end
                WARM: begin
                    if (adc_data_en && (disc_cnt == DISC_LAST)) begin
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (last_smp) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from state and FIFO head; stream fields read zero when empty.
    always_comb begin
        adc_run   = (state == WARM) || (state == CAPTURE);
        busy      = (state != IDLE);
        smp_valid = !fifo_empty;
        smp_data  = '0;
        smp_last  = 1'b0;
        if (!fifo_empty) begin
            smp_data = mem[rd_ptr[FIFO_AW-1:0]][DATA_W-1:0];
            smp_last = mem[rd_ptr[FIFO_AW-1:0]][DATA_W];
        end
        done = done_q;
        ovf  = ovf_q;
    end

    // FIFO storage; contents only matter behind valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {last_smp, adc_data};
        end
    end

    // Window counters, FIFO pointers and the done/ovf flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            guard_cnt <= '0;
            len_q     <= '0;
            smp_cnt   <= '0;
            disc_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (abort_act) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end

            if (start) begin
                len_q     <= cfg_len;
                guard_cnt <= cfg_guard;
                smp_cnt   <= '0;
                disc_cnt  <= '0;
                ovf_q     <= 1'b0;
                if (cfg_len == '0) begin
                    done_q <= 1'b1;
                end
            end

            if ((state == GUARD) && (guard_cnt != '0)) begin
                guard_cnt <= guard_cnt - GUARD_W'(1);
            end

            if ((state == WARM) && adc_data_en && !abort_act) begin
                disc_cnt <= disc_cnt + 2'd1;
            end

            if (push_req) begin
                smp_cnt <= smp_cnt_inc;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end

            if ((state == DRAIN) && fifo_empty && !abort_act) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nfc_rx_capture_ctrl.sv
// Testbench for nfc_rx_capture_ctrl: a table of per-cycle vectors for the
// normal, overflow, full-with-pop and empty-window cases, followed by
// hand-written abort and reset sequences.
module tb_nfc_rx_capture_ctrl;

    localparam int DATA_W  = 12;
    localparam int GUARD_W = 16;
    localparam int LEN_W   = 16;

    logic               clk;
    logic               rstn;
    logic               tx_done;
    logic               abort;
    logic [GUARD_W-1:0] cfg_guard;
    logic [LEN_W-1:0]   cfg_len;
    logic               adc_run;
    logic               adc_data_en;
    logic [DATA_W-1:0]  adc_data;
    logic               smp_valid;
    logic               smp_ready;
    logic [DATA_W-1:0]  smp_data;
    logic               smp_last;
    logic               busy;
    logic               done;
    logic               ovf;

    // Inputs held for one cycle, and the outputs required in the cycle after.
    typedef struct packed {
        logic               rstn;
        logic               tx;
        logic               ab;
        logic               en;
        logic [DATA_W-1:0]  d;
        logic               rdy;
        logic [GUARD_W-1:0] g;
        logic [LEN_W-1:0]   l;
        logic               run;
        logic               vld;
        logic [DATA_W-1:0]  ed;
        logic               lst;
        logic               bsy;
        logic               dn;
        logic               ov;
        logic               zchk;
    } vec_t;

    vec_t tbl[$];
    vec_t v;
    int   n_vec  = 0;
    int   n_miss = 0;

    nfc_rx_capture_ctrl #(
        .DATA_W (DATA_W),
        .GUARD_W(GUARD_W),
        .LEN_W  (LEN_W),
        .DISCARD(2),
        .FIFO_AW(2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_done    (tx_done),
        .abort      (abort),
        .cfg_guard  (cfg_guard),
        .cfg_len    (cfg_len),
        .adc_run    (adc_run),
        .adc_data_en(adc_data_en),
        .adc_data   (adc_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_data   (smp_data),
        .smp_last   (smp_last),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int tx, input int ab, input int en, input int d,
                                input int rdy, input int g, input int l,
                                input int run, input int vld, input int ed,
                                input int lst, input int bsy, input int dn, input int ov);
        vec_t r;
        r.rstn = 1'b1;
        r.tx   = 1'(tx);
        r.ab   = 1'(ab);
        r.en   = 1'(en);
        r.d    = DATA_W'(d);
        r.rdy  = 1'(rdy);
        r.g    = GUARD_W'(g);
        r.l    = LEN_W'(l);
        r.run  = 1'(run);
        r.vld  = 1'(vld);
        r.ed   = DATA_W'(ed);
        r.lst  = 1'(lst);
        r.bsy  = 1'(bsy);
        r.dn   = 1'(dn);
        r.ov   = 1'(ov);
        r.zchk = 1'b0;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t s);
        rstn        = s.rstn;
        tx_done     = s.tx;
        abort       = s.ab;
        adc_data_en = s.en;
        adc_data    = s.d;
        smp_ready   = s.rdy;
        cfg_guard   = s.g;
        cfg_len     = s.l;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vec_t e);
        logic ok;
        ok = (adc_run === e.run) && (smp_valid === e.vld) && (busy === e.bsy) &&
             (done === e.dn) && (ovf === e.ov);
        if (e.vld) ok = ok && (smp_data === e.ed) && (smp_last === e.lst);
        if (e.zchk) ok = ok && (smp_data === '0) && (smp_last === 1'b0);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("[TB] FAIL %s: got run=%b valid=%b data=%h last=%b busy=%b done=%b ovf=%b, expected run=%b valid=%b data=%h last=%b busy=%b done=%b ovf=%b",
                     tag, adc_run, smp_valid, smp_data, smp_last, busy, done, ovf,
                     e.run, e.vld, e.ed, e.lst, e.bsy, e.dn, e.ov);
        end
    endtask

    task automatic step(input string tag, input vec_t s);
        applyStimulus(s);
        checkOutput(tag, s);
    endtask

    initial begin
        // Reset state.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rstn = 1'b0;
        v.zchk = 1'b1;
        applyStimulus(v);
        step("reset", v);

        // Basic window: guard 5, length 4, two warm-up conversions dropped.
        tbl.push_back(mk(1, 0, 0, 0,     1, 5, 4, 0, 0, 0,     0, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 5, 4, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 5, 4, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h100, 1, 5, 4, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h101, 1, 5, 4, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h102, 1, 5, 4, 1, 1, 'h102, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h103, 1, 5, 4, 1, 1, 'h103, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h104, 1, 5, 4, 1, 1, 'h104, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h105, 1, 5, 4, 0, 1, 'h105, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 5, 4, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 5, 4, 0, 0, 0,     0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 5, 4, 0, 0, 0,     0, 0, 0, 0));

        // Overflow: guard 0, length 8, consumer stalled through capture.
        tbl.push_back(mk(1, 0, 0, 0,     0, 0, 8, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h200, 0, 0, 8, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h201, 0, 0, 8, 1, 0, 0,     0, 1, 0, 0));
        for (int i = 2; i < 6; i++)
            tbl.push_back(mk(0, 0, 1, 'h200 + i, 0, 0, 8, 1, 1, 'h202, 0, 1, 0, 0));
        for (int i = 6; i < 9; i++)
            tbl.push_back(mk(0, 0, 1, 'h200 + i, 0, 0, 8, 1, 1, 'h202, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 'h209, 0, 0, 8, 0, 1, 'h202, 0, 1, 0, 1));
        for (int i = 3; i < 6; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8, 0, 1, 'h200 + i, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,     1, 0, 8, 0, 0, 0,     0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,     1, 0, 8, 0, 0, 0,     0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,     1, 0, 8, 0, 0, 0,     0, 0, 0, 1));

        // Full FIFO with same-cycle pop, plus a tx_done ignored during capture.
        tbl.push_back(mk(1, 0, 0, 0,     0, 1, 5, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 1, 5, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h300, 0, 1, 5, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h301, 0, 1, 5, 1, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h302, 0, 1, 5, 1, 1, 'h302, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h303, 0, 1, 5, 1, 1, 'h302, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 'h304, 0, 1, 5, 1, 1, 'h302, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h305, 0, 1, 5, 1, 1, 'h302, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h306, 1, 1, 5, 0, 1, 'h303, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 5, 0, 1, 'h304, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 5, 0, 1, 'h305, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 5, 0, 1, 'h306, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 5, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 5, 0, 0, 0,     0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 5, 0, 0, 0,     0, 0, 0, 0));

        // Empty window: done next cycle, ADC never enabled.
        tbl.push_back(mk(1, 0, 0, 0,     0, 3, 0, 0, 0, 0,     0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 3, 0, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 3, 0, 0, 0, 0,     0, 0, 0, 0));

        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(v);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), tbl[i]);
        end

        // Abort in the same cycle as a strobe: nothing stored, no done.
        step("abort_start", mk(1, 0, 0, 0,     0, 0, 6, 1, 0, 0,     0, 1, 0, 0));
        step("abort_warm0", mk(0, 0, 1, 'h3F0, 0, 0, 6, 1, 0, 0,     0, 1, 0, 0));
        step("abort_warm1", mk(0, 0, 1, 'h3F1, 0, 0, 6, 1, 0, 0,     0, 1, 0, 0));
        step("abort_cap0",  mk(0, 0, 1, 'h401, 0, 0, 6, 1, 1, 'h401, 0, 1, 0, 0));
        step("abort_cap1",  mk(0, 0, 1, 'h402, 0, 0, 6, 1, 1, 'h401, 0, 1, 0, 0));
        step("abort_edge",  mk(0, 1, 1, 'h403, 1, 0, 6, 0, 0, 0,     0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("abort_nodone", mk(0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0));
        step("post_abort_start", mk(1, 0, 0, 0,     1, 0, 1, 1, 0, 0,     0, 1, 0, 0));
        step("post_abort_warm0", mk(0, 0, 1, 'h3F2, 1, 0, 1, 1, 0, 0,     0, 1, 0, 0));
        step("post_abort_warm1", mk(0, 0, 1, 'h3F3, 1, 0, 1, 1, 0, 0,     0, 1, 0, 0));
        step("post_abort_cap",   mk(0, 0, 1, 'h4AA, 1, 0, 1, 0, 1, 'h4AA, 1, 1, 0, 0));
        step("post_abort_drain", mk(0, 0, 0, 0,     1, 0, 1, 0, 0, 0,     0, 1, 0, 0));
        step("post_abort_done",  mk(0, 0, 0, 0,     1, 0, 1, 0, 0, 0,     0, 0, 1, 0));

        // Reset during DRAIN with data pending and ovf set.
        step("rst_start", mk(1, 0, 0, 0,     0, 0, 5, 1, 0, 0,     0, 1, 0, 0));
        step("rst_warm0", mk(0, 0, 1, 'h4F0, 0, 0, 5, 1, 0, 0,     0, 1, 0, 0));
        step("rst_warm1", mk(0, 0, 1, 'h4F1, 0, 0, 5, 1, 0, 0,     0, 1, 0, 0));
        for (int i = 1; i < 5; i++)
            step("rst_cap", mk(0, 0, 1, 'h500 + i, 0, 0, 5, 1, 1, 'h501, 0, 1, 0, 0));
        step("rst_drop_last", mk(0, 0, 1, 'h505, 0, 0, 5, 0, 1, 'h501, 0, 1, 0, 1));
        v = mk(1, 0, 1, 'h506, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        v.rstn = 1'b0;
        v.zchk = 1'b1;
        step("rst_in_drain", v);
        step("clean_start", mk(1, 0, 0, 0,     0, 2, 1, 0, 0, 0,     0, 1, 0, 0));
        step("clean_guard", mk(0, 0, 0, 0,     0, 2, 1, 0, 0, 0,     0, 1, 0, 0));
        step("clean_run",   mk(0, 0, 0, 0,     0, 2, 1, 1, 0, 0,     0, 1, 0, 0));
        step("clean_warm0", mk(0, 0, 1, 'h5F0, 1, 2, 1, 1, 0, 0,     0, 1, 0, 0));
        step("clean_warm1", mk(0, 0, 1, 'h5F1, 1, 2, 1, 1, 0, 0,     0, 1, 0, 0));
        step("clean_cap",   mk(0, 0, 1, 'h5AA, 1, 2, 1, 0, 1, 'h5AA, 1, 1, 0, 0));
        step("clean_drain", mk(0, 0, 0, 0,     1, 2, 1, 0, 0, 0,     0, 1, 0, 0));
        step("clean_done",  mk(0, 0, 0, 0,     1, 2, 1, 0, 0, 0,     0, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
